// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding, default widths and a clog2 helper
// used by the multicore bus arbiter and the external memory model.
package bus_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NCORES = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/multicore_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority finder. Searches req_i starting
// at ptr_i, wrapping at N-1 -> 0, and returns the first set index.
module rr_picker
    import bus_pkg::*;
#(
    parameter int N  = DEF_NCORES,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] winner_o,
    output logic          valid_o
);

    // First requester at or after the pointer, owner position searched last.
    always_comb begin
        int            idx;
        logic [IW-1:0] sel;
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        sel      = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            sel = idx[IW-1:0];
            if (!valid_o && req_i[sel]) begin
                valid_o  = 1'b1;
                winner_o = sel;
            end else begin
                valid_o  = valid_o;
            end
        end
    end

endmodule

// File: rtl/multicore_bus_arbiter.sv
// Round-robin arbiter granting NCORES cores the shared memory/IO port.
// Optional grant timeout is compiled in with `define ARB_TIMEOUT_EN.
module multicore_bus_arbiter
    import bus_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NCORES   = DEF_NCORES,
    parameter int IDXBITS  = clog2(NCORES),
    parameter int MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCORES-1:0]       request,
    input  logic [NCORES*WIDTH-1:0] adr_in,
    input  logic [NCORES*WIDTH-1:0] writedata_in,
    input  logic [NCORES-1:0]       memwrite_in,
    output logic [NCORES-1:0]       grant,
    output logic [WIDTH-1:0]        adr,
    output logic [WIDTH-1:0]        writedata,
    output logic                    memwrite,
    output logic [IDXBITS-1:0]      owner,
    output logic                    busy
);

    if (MAX_HOLD < 2 || NCORES < 2 || NCORES > 16) begin : g_param_err
        $error("multicore_bus_arbiter: parameter out of range");
    end

    arb_state_e         state_q, state_d;
    logic [IDXBITS-1:0] owner_q, owner_d;
    logic [IDXBITS-1:0] ptr_s;
    logic [IDXBITS-1:0] winner_s;
    logic               pick_valid_s;

`ifdef ARB_TIMEOUT_EN
    localparam int HCW = clog2(MAX_HOLD);
    logic [HCW-1:0] hold_q, hold_d;
`endif

    assign ptr_s = (owner_q == IDXBITS'(NCORES - 1)) ? '0 : owner_q + IDXBITS'(1);

    rr_picker #(
        .N  (NCORES),
        .IW (IDXBITS)
    ) u_picker (
        .req_i    (request),
        .ptr_i    (ptr_s),
        .winner_o (winner_s),
        .valid_o  (pick_valid_s)
    );

    // State, owner and hold counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    // Next-state: grant on idle, hold while owner requests, hand over without a bubble.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
`ifdef ARB_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    state_d = OWNED;
                    owner_d = winner_s;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            OWNED: begin
                if (request[owner_q]) begin
`ifdef ARB_TIMEOUT_EN
                    // At the limit the owner yields only if someone else is waiting.
                    if (hold_q == HCW'(MAX_HOLD - 1)) begin
                        if (pick_valid_s && (winner_s != owner_q)) begin
                            owner_d = winner_s;
                            hold_d  = '0;
                        end else begin
                            hold_d  = hold_q;
                        end
                    end else begin
                        hold_d = hold_q + HCW'(1);
                    end
`else
                    owner_d = owner_q;
`endif
                end else if (pick_valid_s) begin
                    owner_d = winner_s;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: grant decoded from registered state; datapath muxed by owner.
    always_comb begin
        grant = '0;
        if (state_q == OWNED) begin
            grant[owner_q] = 1'b1;
        end else begin
            grant = '0;
        end
        busy      = (state_q == OWNED);
        owner     = owner_q;
        adr       = adr_in[int'(owner_q)*WIDTH +: WIDTH];
        writedata = writedata_in[int'(owner_q)*WIDTH +: WIDTH];
        memwrite  = busy & request[owner_q] & memwrite_in[owner_q];
    end

endmodule

// File: tb/tb_multicore_bus_arbiter.sv
// Scoreboard bench for multicore_bus_arbiter (NCORES=4, WIDTH=8, MAX_HOLD=16);
// expectations adapt to whether ARB_TIMEOUT_EN is defined.
module tb_multicore_bus_arbiter;

    typedef logic [23:0] exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  request;
    logic [31:0] adr_in;
    logic [31:0] writedata_in;
    logic [3:0]  memwrite_in;
    logic [3:0]  grant;
    logic [7:0]  adr;
    logic [7:0]  writedata;
    logic        memwrite;
    logic [1:0]  owner;
    logic        busy;

    logic [7:0]  addr_tab [4];
    logic [7:0]  wd_tab   [4];
    bit   [7:0]  mem      [256];

    exp_t        exp_q  [$];
    string       name_q [$];
    int          total = 0;
    int          bad   = 0;

    multicore_bus_arbiter #(
        .WIDTH    (8),
        .NCORES   (4),
        .IDXBITS  (2),
        .MAX_HOLD (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .request      (request),
        .adr_in       (adr_in),
        .writedata_in (writedata_in),
        .memwrite_in  (memwrite_in),
        .grant        (grant),
        .adr          (adr),
        .writedata    (writedata),
        .memwrite     (memwrite),
        .owner        (owner),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Simple external memory: records every write that reaches the port.
    always @(posedge clk) begin
        if (memwrite) mem[adr] <= writedata;
    end

    function automatic exp_t mk(input logic [3:0] g, input logic [1:0] o,
                                input logic [3:0] req, input logic [3:0] mw);
        logic b;
        b = |g;
        return {g, o, b, addr_tab[o], wd_tab[o], b & req[o] & mw[o]};
    endfunction

    // Monitor: compares DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        exp_t  e;
        exp_t  act;
        string nm;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {grant, owner, busy, adr, writedata, memwrite};
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got {grant,owner,busy,adr,wd,mw}=%b_%0d_%b_%h_%h_%b want %b_%0d_%b_%h_%h_%b",
                         nm, act[23:20], act[19:18], act[17], act[16:9], act[8:1], act[0],
                         e[23:20], e[19:18], e[17], e[16:9], e[8:1], e[0]);
            end
        end
    end

    task automatic step(input logic [3:0] req, input logic [3:0] mw,
                        input logic [3:0] g, input logic [1:0] o, input string nm);
        request     = req;
        memwrite_in = mw;
        @(posedge clk);
        exp_q.push_back(mk(g, o, req, mw));
        name_q.push_back(nm);
        @(negedge clk);
        #1;
    endtask

    task automatic async_reset_pulse();
        @(posedge clk);
        #1;
        request     = 4'b0010;
        memwrite_in = 4'b0010;
        reset       = 1'b1;
        exp_q.push_back(mk(4'b0000, 2'd0, 4'b0010, 4'b0010));
        name_q.push_back("async_reset");
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] onehot;
        logic [3:0] drop;
        int         nxt;

        addr_tab     = '{8'h10, 8'h20, 8'h30, 8'h40};
        wd_tab       = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        adr_in       = {8'h40, 8'h30, 8'h20, 8'h10};
        writedata_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        request      = 4'b0000;
        memwrite_in  = 4'b0000;
        reset        = 1'b1;
        exp_q.push_back(mk(4'b0000, 2'd0, 4'b0000, 4'b0000));
        name_q.push_back("reset_state");
        @(negedge clk);
        #1;
        reset = 1'b0;

        step(4'b0000, 4'b0000, 4'b0000, 2'd0, "idle_no_req");
        step(4'b0100, 4'b0000, 4'b0100, 2'd2, "grant_core2");
        step(4'b0100, 4'b0001, 4'b0100, 2'd2, "nonowner_write");
        step(4'b0100, 4'b0101, 4'b0100, 2'd2, "owner_write");
        step(4'b0000, 4'b0000, 4'b0000, 2'd2, "release_idle");

        step(4'b1000, 4'b0000, 4'b1000, 2'd3, "grant_core3");
        step(4'b0000, 4'b0000, 4'b0000, 2'd3, "idle_keep_owner");

        step(4'b1111, 4'b0000, 4'b0001, 2'd0, "rr_first");
        for (int k = 0; k < 4; k++) begin
            onehot = 4'b0001 << k;
            step(4'b1111, 4'b0000, onehot, 2'(k), "rr_hold");
            step(4'b1111, 4'b0000, onehot, 2'(k), "rr_hold");
            drop   = 4'b1111 & ~onehot;
            nxt    = (k + 1) % 4;
            onehot = 4'b0001 << nxt;
            step(drop, 4'b0000, onehot, 2'(nxt), "rr_handover");
        end
        step(4'b0000, 4'b0000, 4'b0000, 2'd0, "rr_idle");

        step(4'b0010, 4'b0000, 4'b0010, 2'd1, "grant_core1");
        for (int i = 1; i <= 40; i++) begin
`ifdef ARB_TIMEOUT_EN
            if (i >= 16 && i < 32) step(4'b1010, 4'b0000, 4'b1000, 2'd3, "timeout_rotate");
            else                   step(4'b1010, 4'b0000, 4'b0010, 2'd1, "timeout_hold");
`else
            step(4'b1010, 4'b0000, 4'b0010, 2'd1, "hold_forever");
`endif
        end

        async_reset_pulse();
        step(4'b0010, 4'b0000, 4'b0010, 2'd1, "regrant_after_reset");
        step(4'b0000, 4'b0000, 4'b0000, 2'd1, "final_idle");

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
        end

        total++;
        if (mem[8'h10] !== 8'h00) begin
            bad++;
            $display("FAIL mem_core0: got %h want 00", mem[8'h10]);
        end
        total++;
        if (mem[8'h30] !== 8'hA2) begin
            bad++;
            $display("FAIL mem_core2: got %h want a2", mem[8'h30]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicore_bus_arbiter.md
# multicore_bus_arbiter

Parametrised successor to the two-core system bus: arbitrates NCORES requesters onto the single external memory/IO port with registered one-hot grants, fair round-robin rotation and grant hold for multi-cycle transactions. Sits between the array of mips cores and extememory. It drives the shared address, write data and write enable from the current owner.

## Interface
- WIDTH, 8, data and address width per core
- NCORES, 4, number of requesting cores (2..16)
- IDXBITS, clog2(NCORES), owner index width
- MAX_HOLD, 16, maximum consecutive owned cycles when timeout is compiled in (≥2)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- request  in  NCORES  per-core request (memread | memwrite)
- adr_in  in  NCORES*WIDTH  packed core addresses, core i at [i*WIDTH +: WIDTH]
- writedata_in  in  NCORES*WIDTH  packed core write data, same packing
- memwrite_in  in  NCORES  per-core write strobe
- grant  out  NCORES  registered one-hot grant (all-zero when idle)
- adr  out  WIDTH  owner's address
- writedata  out  WIDTH  owner's write data
- memwrite  out  1  owner's write strobe, gated
- owner  out  IDXBITS  registered index of current/last owner
- busy  out  1  high while any grant is asserted

## Operation
- States: IDLE (grant = 0), OWNED (exactly one grant bit high).
- Reset: state IDLE, grant 0, owner 0, busy 0, hold counter 0; outputs adr/writedata = adr_in/writedata_in slice 0, memwrite 0.
- Arbitration evaluated every edge; pointer = owner+1 mod NCORES; winner = first set request bit searching pointer, pointer+1, … wrapping (owner itself searched last).
- IDLE: any request → OWNED, grant[winner], owner ← winner; none → stay IDLE.
- OWNED, request[owner] high: keep grant (hold), unless timeout forces rotation (see Configuration).
- OWNED, request[owner] low: other requests → grant moves to winner at that edge (no bubble cycle); none → IDLE, grant 0, owner retains value.
- Outputs: adr/writedata combinationally muxed by owner; memwrite = busy & request[owner] & memwrite_in[owner]. Ungranted cores never reach memory.
- Simultaneous requests from all cores: served in strict rotation, each core at most once before any repeat.
- Request dropped by a non-owner before being granted: no effect, no grant issued.
- NCORES not a power of two: pointer wraps at NCORES-1 → 0; indices ≥ NCORES never granted.

## Timing
- Grant latency: request high before edge k → grant high after edge k (1 cycle) when bus idle.
- Handover: owner drops request before edge k → new grant visible after edge k; old grant low same edge.
- Core must hold request until it sees its grant and completes its access; grant is registered, so a core drops request the cycle after its access.
- reset asserted mid-transaction: grant/busy/memwrite go low asynchronously, no write reaches memory that cycle.

## Configuration
- ARB_TIMEOUT_EN defined: hold counter increments each OWNED hold cycle, clears on any grant change. When count reaches MAX_HOLD-1 and another core requests, grant rotates to winner at next edge even if owner still requests; if no other requester, owner keeps grant and counter saturates.
- Undefined: no counter; owner holds indefinitely while request stays high.

## Structure
- Shared package bus_pkg: arbiter state enum (IDLE, OWNED), clog2 function, default WIDTH/NCORES constants reused by top level and extememory.
- One sub-module: rr_picker — combinational round-robin priority finder (request vector, pointer → winner index, valid).

## Test plan
- Reset, NCORES=4, request=4'b0000 → grant=0, busy=0, memwrite=0, owner=0.
- request=4'b0100 from idle → grant=4'b0100 one cycle later, owner=2, adr=adr_in slice 2.
- request=4'b1111 held, each owner drops for one cycle after 3 cycles → grant sequence 0001,0010,0100,1000,0001 with no idle cycle between.
- Owner 1 holds request 40 cycles, core 3 requesting; with ARB_TIMEOUT_EN, MAX_HOLD=16 → grant moves to 3 after 16 owned cycles; without macro → stays on 1 all 40 cycles.
- Core 0 asserts memwrite_in=1 while core 2 owns → memwrite follows core 2 only; extememory contents at core 0 address unchanged.
- reset pulsed mid-hold with grant=4'b0010 → grant=0 immediately (before next edge); after release request=4'b0010 regranted one cycle later.
